cbus_rr_arbiter: RTL and testbench

- Parametrised successor to the fixed-priority CBus arbiter. Multiplexes NUM_INPUTS cbus requesters onto one cbus master port.
- Selectable fixed-priority or round-robin arbitration, plus starvation-age override and abort-on-drop release.
- Sits between the core's I/D-side cbus masters and the downstream MMU/PMP/memory path.
- Grant is held for the whole burst, until oresp.last.

---
 rtl/cbus_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_cbus_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_rr_arbiter.sv
// CBus requester arbiter: funnels NUM_INPUTS cbus masters onto one downstream
// port, holding the grant for a whole burst (until oresp.last or requester abort).
// Arbitration is fixed-priority or round-robin, with an age override that
// force-grants any requester that has lost MAX_WAIT rounds in a row.

package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cbus_req_t;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [31:0] rdata;
    } cbus_resp_t;
endpackage

// state | meaning
// IDLE  | no grant; oreq idle; picks a winner when any requester is valid
// BUSY  | index owns the downstream port until last or its valid drops
module cbus_rr_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int RR_MODE    = 1,
    parameter int MAX_WAIT   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs  [NUM_INPUTS],
    output cbus_resp_t iresps [NUM_INPUTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output logic       grant_valid,
    output logic [((NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1)-1:0] grant_index
);

    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AGE_W-1:0]   age_q [NUM_INPUTS];
    logic [AGE_W-1:0]   age_d [NUM_INPUTS];
    logic [IDX_W-1:0]   winner;
    logic               any_valid;

    // Winner select: starved requesters first, then fixed or rotating priority.
    always_comb begin
        logic             aged_found;
        logic             found;
        logic [IDX_W-1:0] sel;
        int               j;
        winner     = '0;
        any_valid  = 1'b0;
        aged_found = 1'b0;
        found      = 1'b0;
        sel        = '0;
        j          = 0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (ireqs[i].valid) begin
                any_valid = 1'b1;
            end
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!aged_found && ireqs[i].valid && (age_q[i] >= AGE_W'(MAX_WAIT))) begin
                aged_found = 1'b1;
                winner     = IDX_W'(i);
            end
        end
        if (!aged_found) begin
            if (RR_MODE == 0) begin
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (!found && ireqs[i].valid) begin
                        found  = 1'b1;
                        winner = IDX_W'(i);
                    end
                end
            end else begin
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    j = int'(rr_ptr_q) + k;
                    if (j >= NUM_INPUTS) begin
                        j = j - NUM_INPUTS;
                    end
                    sel = IDX_W'(j);
                    if (!found && ireqs[sel].valid) begin
                        found  = 1'b1;
                        winner = sel;
                    end
                end
            end
        end
    end

    // Next-state, age bookkeeping and the burst passthrough muxes.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        rr_ptr_d = rr_ptr_q;
        age_d    = age_q;
        oreq     = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
        end
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = BUSY;
                    index_d = winner;
                    for (int i = 0; i < NUM_INPUTS; i++) begin
                        if (IDX_W'(i) == winner) begin
                            age_d[i] = '0;
                        end else if (ireqs[i].valid) begin
                            age_d[i] = (age_q[i] >= AGE_W'(MAX_WAIT)) ? AGE_W'(MAX_WAIT)
                                                                      : age_q[i] + 1'b1;
                        end else begin
                            age_d[i] = '0;
                        end
                    end
                end
            end
            BUSY: begin
                // Passthrough keeps write data/strobes live for the whole burst.
                oreq            = ireqs[index_q];
                iresps[index_q] = oresp;
                // Completion and abort both release; coinciding is one release.
                if (oresp.last || !ireqs[index_q].valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = ((int'(index_q) + 1) >= NUM_INPUTS) ? '0 : index_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            index_q  <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign grant_valid = (state_q == BUSY);
    assign grant_index = index_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter: one fixed-priority 2-input instance and one
// round-robin 4-input instance share clock and reset. Expected grant indices
// are queued when a scenario is set up and popped when each grant starts.
module tb_cbus_rr_arbiter;
    import cbus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cbus_req_t  fp_ireqs  [2];
    cbus_resp_t fp_iresps [2];
    cbus_req_t  fp_oreq;
    cbus_resp_t fp_oresp;
    logic       fp_gv;
    logic [0:0] fp_gi;

    cbus_req_t  rr_ireqs  [4];
    cbus_resp_t rr_iresps [4];
    cbus_req_t  rr_oreq;
    cbus_resp_t rr_oresp;
    logic       rr_gv;
    logic [1:0] rr_gi;

    cbus_rr_arbiter #(.NUM_INPUTS(2), .RR_MODE(0), .MAX_WAIT(4)) dut_fp (
        .clk(clk), .reset(reset), .ireqs(fp_ireqs), .iresps(fp_iresps),
        .oreq(fp_oreq), .oresp(fp_oresp), .grant_valid(fp_gv), .grant_index(fp_gi)
    );

    cbus_rr_arbiter #(.NUM_INPUTS(4), .RR_MODE(1), .MAX_WAIT(4)) dut_rr (
        .clk(clk), .reset(reset), .ireqs(rr_ireqs), .iresps(rr_iresps),
        .oreq(rr_oreq), .oresp(rr_oresp), .grant_valid(rr_gv), .grant_index(rr_gi)
    );

    int vectors = 0;
    int errors  = 0;
    int fp_q[$];
    int rr_q[$];
    int fp_beat = 0, rr_beat = 0;
    int fp_len = 0, rr_len = 0;
    int rr_idle = 0;
    bit rr_seen = 1'b0;
    bit rr_gap_chk = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance downstream responders, shuffle payloads, check muxes, score grants.
    task automatic tick();
        int e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            fp_ireqs[i].write = 1'($urandom());
            fp_ireqs[i].addr  = 16'($urandom());
            fp_ireqs[i].wdata = $urandom();
            fp_ireqs[i].wstrb = 4'($urandom());
        end
        for (int i = 0; i < 4; i++) begin
            rr_ireqs[i].write = 1'($urandom());
            rr_ireqs[i].addr  = 16'($urandom());
            rr_ireqs[i].wdata = $urandom();
            rr_ireqs[i].wstrb = 4'($urandom());
        end
        if (fp_gv) fp_beat++; else fp_beat = 0;
        if (rr_gv) rr_beat++; else rr_beat = 0;
        fp_oresp.valid = fp_gv;
        fp_oresp.last  = fp_gv && (fp_len != 0) && (fp_beat == fp_len);
        fp_oresp.rdata = fp_gv ? (32'hF000_0000 + 32'(fp_beat)) : 32'h0;
        rr_oresp.valid = rr_gv;
        rr_oresp.last  = rr_gv && (rr_len != 0) && (rr_beat == rr_len);
        rr_oresp.rdata = rr_gv ? (32'hB000_0000 + 32'(rr_beat)) : 32'h0;
        #1;
        if (fp_gv) begin
            check_eq("fp_oreq_pass", 64'(fp_oreq), 64'(fp_ireqs[fp_gi]));
            for (int i = 0; i < 2; i++)
                check_eq("fp_iresp", 64'(fp_iresps[i]), (i == int'(fp_gi)) ? 64'(fp_oresp) : 64'h0);
        end else begin
            check_eq("fp_oreq_idle", 64'(fp_oreq), 64'h0);
            for (int i = 0; i < 2; i++) check_eq("fp_iresp_idle", 64'(fp_iresps[i]), 64'h0);
        end
        if (rr_gv) begin
            check_eq("rr_oreq_pass", 64'(rr_oreq), 64'(rr_ireqs[rr_gi]));
            for (int i = 0; i < 4; i++)
                check_eq("rr_iresp", 64'(rr_iresps[i]), (i == int'(rr_gi)) ? 64'(rr_oresp) : 64'h0);
        end else begin
            check_eq("rr_oreq_idle", 64'(rr_oreq), 64'h0);
            for (int i = 0; i < 4; i++) check_eq("rr_iresp_idle", 64'(rr_iresps[i]), 64'h0);
        end
        if (fp_gv && fp_beat == 1) begin
            if (fp_q.size() == 0) begin
                check_eq("fp_spurious_grant", 64'(1), 64'(0));
            end else begin
                e = fp_q.pop_front();
                check_eq("fp_grant_idx", 64'(fp_gi), 64'(e));
            end
        end
        if (!rr_gv) rr_idle++;
        if (rr_gv && rr_beat == 1) begin
            if (rr_gap_chk && rr_seen) check_eq("rr_idle_gap", 64'(rr_idle), 64'(1));
            rr_seen = 1'b1;
            rr_idle = 0;
            if (rr_q.size() == 0) begin
                check_eq("rr_spurious_grant", 64'(1), 64'(0));
            end else begin
                e = rr_q.pop_front();
                check_eq("rr_grant_idx", 64'(rr_gi), 64'(e));
            end
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < 2; i++) fp_ireqs[i] = '0;
        for (int i = 0; i < 4; i++) rr_ireqs[i] = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) begin
            tick();
            check_eq("rst_fp_gv", 64'(fp_gv), 64'(0));
            check_eq("rst_fp_gi", 64'(fp_gi), 64'(0));
            check_eq("rst_rr_gv", 64'(rr_gv), 64'(0));
            check_eq("rst_rr_oreq_valid", 64'(rr_oreq.valid), 64'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_reqs();
        fp_oresp = '0;
        rr_oresp = '0;

        // Reset held with every requester valid.
        for (int i = 0; i < 2; i++) fp_ireqs[i].valid = 1'b1;
        for (int i = 0; i < 4; i++) rr_ireqs[i].valid = 1'b1;
        do_reset(3);

        // Fixed priority with age override, and round-robin over 0,2,3.
        rr_ireqs[1].valid = 1'b0;
        fp_len = 3;
        rr_len = 1;
        rr_gap_chk = 1'b1;
        rr_seen = 1'b0;
        foreach (fp_q[i]) fp_q.delete(i);
        fp_q = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        rr_q = '{0, 2, 3, 0, 2, 3};
        reset = 1'b1;
        check_eq("release_fp_gv_low", 64'(fp_gv), 64'(0));
        tick();
        check_eq("release_fp_gv_high", 64'(fp_gv), 64'(1));
        check_eq("release_fp_gi", 64'(fp_gi), 64'(0));
        check_eq("release_rr_gi", 64'(rr_gi), 64'(0));
        for (int c = 0; c < 200 && (fp_q.size() != 0 || rr_q.size() != 0); c++) begin
            if (rr_q.size() == 0) for (int i = 0; i < 4; i++) rr_ireqs[i].valid = 1'b0;
            tick();
        end
        for (int i = 0; i < 2; i++) fp_ireqs[i].valid = 1'b0;
        for (int i = 0; i < 4; i++) rr_ireqs[i].valid = 1'b0;
        check_eq("fp_seq_left", 64'(fp_q.size()), 64'(0));
        check_eq("rr_seq_left", 64'(rr_q.size()), 64'(0));
        rr_gap_chk = 1'b0;
        tick();
        tick();

        // Burst hold: input 1 owns a 4-beat burst while input 0 waits.
        clear_reqs();
        do_reset(2);
        fp_ireqs[1].valid = 1'b1;
        fp_len = 4;
        fp_q.push_back(1);
        reset = 1'b1;
        tick();
        fp_ireqs[0].valid = 1'b1;
        for (int b = 2; b <= 4; b++) begin
            tick();
            check_eq("hold_gi", 64'(fp_gi), 64'(1));
            check_eq("hold_iresp0", 64'(fp_iresps[0]), 64'h0);
        end
        check_eq("hold_last_seen", 64'(fp_iresps[1].last), 64'(1));
        tick();
        check_eq("hold_bubble", 64'(fp_gv), 64'(0));
        fp_ireqs[1].valid = 1'b0;
        fp_q.push_back(0);
        tick();
        check_eq("hold_next_gv", 64'(fp_gv), 64'(1));
        check_eq("hold_next_gi", 64'(fp_gi), 64'(0));
        fp_ireqs[0].valid = 1'b0;
        tick();
        tick();

        // Abort: granted input 1 drops valid on its 2nd cycle, input 0 pending.
        clear_reqs();
        do_reset(2);
        rr_ireqs[1].valid = 1'b1;
        rr_len = 0;
        rr_q.push_back(1);
        reset = 1'b1;
        tick();
        rr_ireqs[0].valid = 1'b1;
        tick();
        rr_ireqs[1].valid = 1'b0;
        #1;
        check_eq("abort_oreq_valid", 64'(rr_oreq.valid), 64'(0));
        check_eq("abort_gv_still", 64'(rr_gv), 64'(1));
        rr_q.push_back(0);
        tick();
        check_eq("abort_idle", 64'(rr_gv), 64'(0));
        tick();
        check_eq("abort_next_gv", 64'(rr_gv), 64'(1));
        check_eq("abort_next_gi", 64'(rr_gi), 64'(0));
        rr_ireqs[0].valid = 1'b0;
        tick();
        tick();

        // Completion and abort in the same cycle.
        clear_reqs();
        do_reset(2);
        fp_ireqs[1].valid = 1'b1;
        fp_len = 2;
        fp_q.push_back(1);
        reset = 1'b1;
        tick();
        tick();
        fp_ireqs[1].valid = 1'b0;
        #1;
        check_eq("simul_iresp1", 64'(fp_iresps[1]), 64'(fp_oresp));
        check_eq("simul_last", 64'(fp_iresps[1].last), 64'(1));
        check_eq("simul_oreq_valid", 64'(fp_oreq.valid), 64'(0));
        tick();
        check_eq("simul_idle1", 64'(fp_gv), 64'(0));
        tick();
        check_eq("simul_idle2", 64'(fp_gv), 64'(0));
        check_eq("simul_q_left", 64'(fp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
